elastic_register_pipeline: RTL and testbench
============================================

// Module: elastic_register_pipeline
// PURPOSE
//   Valid/ready register pipeline of NUM_STAGES stages. The downstream consumer drives
//   back-pressure through DOUT_READY; there is no global clock enable.
//   Bubble-collapsing: an empty stage accepts data even while later stages stall.
//   Sits between a producer and a consumer that may stall, where a pipelined path is
//   needed for timing closure without losing data.
// PARAMETERS
//   DATA_WIDTH  1  payload width in bits
//   NUM_STAGES  1  number of register stages; must be >= 1
// PORTS
//   CLK         in   1                        clock; single clock domain
//   RSTN        in   1                        asynchronous, active-low reset
//   DIN_VALID   in   1                        producer has a word on DIN
//   DIN_READY   out  1                        pipeline accepts DIN this cycle
//   DIN         in   DATA_WIDTH               input payload
//   DOUT_VALID  out  1                        stage NUM_STAGES-1 holds a word
//   DOUT_READY  in   1                        consumer accepts DOUT this cycle
//   DOUT        out  DATA_WIDTH               output payload
//   OCCUPANCY   out  $clog2(NUM_STAGES+1)     number of valid stages
// BEHAVIOUR
// - Per-stage state: vld[i] and dat[i]; stage 0 is fed by DIN, stage NUM_STAGES-1 drives DOUT.
// - Reset (RSTN=0, asynchronous): all vld[i]=0 and dat[i]=0.
//   Resulting outputs: DOUT_VALID=0, DOUT=0, OCCUPANCY=0.
//   DIN_READY=1 as soon as reset is asserted; it is combinational from the empty state.
// - Reset mid-operation drops all in-flight words; nothing is emitted after RSTN rises.
// - Advance terms, combinational from the last stage back to stage 0:
//     adv[N-1] = !vld[N-1] | DOUT_READY
//     adv[i]   = !vld[i]   | adv[i+1]
//   DIN_READY = adv[0].
// - Combinational paths: the ready chain is combinational from DOUT_READY to DIN_READY;
//   DOUT and DOUT_VALID are registered.
// - Clock edge, per stage i where adv[i]=1:
//     vld[i] <= input valid (DIN_VALID for i=0, else vld[i-1])
//     dat[i] <= input data  (DIN for i=0, else dat[i-1])
// - Data register update: dat[i] loads only when the input valid is 1; it holds otherwise.
// - Stages with adv[i]=0 hold vld[i] and dat[i].
// - Transfers: a word is accepted on DIN_VALID & DIN_READY and delivered on
//   DOUT_VALID & DOUT_READY.
// - Ordering: words are never duplicated, dropped or reordered.
// - Latency: NUM_STAGES cycles from acceptance to DOUT_VALID into an empty, unstalled pipe.
// - Throughput: 1 word per cycle while DOUT_READY=1.
// - Simultaneous events with the pipe full: DOUT_READY=1 and DIN_VALID=1 shift the whole
//   pipe in one cycle. DIN_READY=1 in that cycle and OCCUPANCY is unchanged.
// - Full pipe with DOUT_READY=0: DIN_READY=0, OCCUPANCY=NUM_STAGES, all state held.
// - Partially filled pipe with DOUT_READY=0: bubbles collapse toward the output, so an
//   empty stage ahead of a stalled stage still fills. OCCUPANCY increases by 1 for each
//   accepted word.
// - OCCUPANCY is registered and updated every cycle: +1 on accept, -1 on deliver,
//   unchanged when both or neither occur. It always equals popcount(vld).
// - DIN is don't-care when DIN_VALID=0; such a cycle inserts no word and leaves OCCUPANCY unchanged.
// - NUM_STAGES=1 degenerates to a single full-throughput register slice.
//   DIN_READY = !vld[0] | DOUT_READY.
// TESTING (DATA_WIDTH=8, NUM_STAGES=4 unless noted)
// 1. Reset: hold RSTN=0 with random inputs -> DOUT_VALID=0, DOUT=0, OCCUPANCY=0,
//    DIN_READY=1. Assert RSTN asynchronously mid-cycle -> outputs clear without a clock edge.
// 2. Streaming: DOUT_READY=1, push 0x01..0x10 back-to-back -> first DOUT_VALID 4 cycles
//    after the first accept; 0x01..0x10 emitted on consecutive cycles.
// 3. Fill and stall: DOUT_READY=0, push 0xA0..0xA5 -> 0xA0..0xA3 accepted, then DIN_READY=0
//    and OCCUPANCY=4. Release DOUT_READY -> 0xA0..0xA5 out in order, OCCUPANCY back to 0.
// 4. Bubble collapse: push 0x11, idle 2 cycles, push 0x22, then DOUT_READY=0 for 6 cycles
//    -> both words held in stages 3 and 2 with OCCUPANCY=2 and DIN_READY=1.
// 5. Full-pipe pass-through: pipe full, DOUT_READY=1 and DIN_VALID=1 for 8 cycles ->
//    DIN_READY=1 every cycle and OCCUPANCY stays 4.
// 6. Random valid/ready at 50% each, 10k words, checked against a scoreboard queue.
//    Repeat with NUM_STAGES=1 and NUM_STAGES=7 -> no loss, duplication or reordering,
//    and OCCUPANCY == model count every cycle.

Source files
------------

// File: rtl/elastic_register_pipeline.sv
// Valid/ready register pipeline with bubble collapsing: any empty stage accepts a word
// even while stages closer to the output are stalled by DOUT_READY.
module elastic_register_pipeline #(
  parameter int DATA_WIDTH = 1,
  parameter int NUM_STAGES = 1
) (
  input  logic                                  CLK,
  input  logic                                  RSTN,
  input  logic                                  DIN_VALID,
  output logic                                  DIN_READY,
  input  logic [DATA_WIDTH-1:0]                 DIN,
  output logic                                  DOUT_VALID,
  input  logic                                  DOUT_READY,
  output logic [DATA_WIDTH-1:0]                 DOUT,
  output logic [$clog2(NUM_STAGES+1)-1:0]       OCCUPANCY
);

  localparam int OCC_W = $clog2(NUM_STAGES+1);

  logic                  r_vld [NUM_STAGES];
  logic [DATA_WIDTH-1:0] r_dat [NUM_STAGES];
  logic [NUM_STAGES-1:0] w_adv;
  logic [OCC_W-1:0]      r_occ;
  logic                  w_acc;
  logic                  w_dlv;

  // A stage advances unless it and every stage after it are full and the consumer stalls.
  always_comb begin : ready_chain
    logic v_full;
    v_full = 1'b1;
    w_adv  = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      v_full   = v_full & r_vld[i];
      w_adv[i] = DOUT_READY | ~v_full;
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    logic                  w_in_vld;
    logic [DATA_WIDTH-1:0] w_in_dat;

    if (g == 0) begin : g_head
      assign w_in_vld = DIN_VALID;
      assign w_in_dat = DIN;
    end else begin : g_body
      assign w_in_vld = r_vld[g-1];
      assign w_in_dat = r_dat[g-1];
    end

    // Data only loads with a valid word so idle cycles leave the payload untouched.
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        r_vld[g] <= 1'b0;
        r_dat[g] <= '0;
      end else if (w_adv[g]) begin
        r_vld[g] <= w_in_vld;
        if (w_in_vld) begin
          r_dat[g] <= w_in_dat;
        end
      end
    end
  end

  assign w_acc = DIN_VALID & w_adv[0];
  assign w_dlv = r_vld[NUM_STAGES-1] & DOUT_READY;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_occ <= '0;
    end else begin
      case ({w_acc, w_dlv})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign DIN_READY  = w_adv[0];
  assign DOUT_VALID = r_vld[NUM_STAGES-1];
  assign DOUT       = r_dat[NUM_STAGES-1];
  assign OCCUPANCY  = r_occ;

endmodule

// File: tb/tb_elastic_register_pipeline.sv
// Directed and randomised checks of elastic_register_pipeline at depths 4, 1 and 7.
// Lane 0 is the depth-4 pipe used for the directed vectors; all lanes run the random phase.
module tb_elastic_register_pipeline;

  logic       clk;
  logic       rstn;
  logic       vin  [3];
  logic       irdy [3];
  logic [7:0] din  [3];
  logic       ovld [3];
  logic       rdy  [3];
  logic [7:0] dout [3];
  logic [2:0] occ_a;
  logic [0:0] occ_b;
  logic [2:0] occ_c;

  int n_chk = 0;
  int n_err = 0;

  elastic_register_pipeline #(.DATA_WIDTH(8), .NUM_STAGES(4)) u_n4 (
    .CLK(clk), .RSTN(rstn), .DIN_VALID(vin[0]), .DIN_READY(irdy[0]), .DIN(din[0]),
    .DOUT_VALID(ovld[0]), .DOUT_READY(rdy[0]), .DOUT(dout[0]), .OCCUPANCY(occ_a));

  elastic_register_pipeline #(.DATA_WIDTH(8), .NUM_STAGES(1)) u_n1 (
    .CLK(clk), .RSTN(rstn), .DIN_VALID(vin[1]), .DIN_READY(irdy[1]), .DIN(din[1]),
    .DOUT_VALID(ovld[1]), .DOUT_READY(rdy[1]), .DOUT(dout[1]), .OCCUPANCY(occ_b));

  elastic_register_pipeline #(.DATA_WIDTH(8), .NUM_STAGES(7)) u_n7 (
    .CLK(clk), .RSTN(rstn), .DIN_VALID(vin[2]), .DIN_READY(irdy[2]), .DIN(din[2]),
    .DOUT_VALID(ovld[2]), .DOUT_READY(rdy[2]), .DOUT(dout[2]), .OCCUPANCY(occ_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] occ_of(input int l);
    case (l)
      0:       return 32'(occ_a);
      1:       return 32'(occ_b);
      default: return 32'(occ_c);
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit r);
    vin[0] = v;
    din[0] = d;
    rdy[0] = r;
    #2;
  endtask

  string occ_tag  [3] = '{"occ_n4", "occ_n1", "occ_n7"};
  string data_tag [3] = '{"data_n4", "data_n1", "data_n7"};

  logic [7:0] mem [3][16];
  int sent [3];
  int got  [3];
  int cnt  [3];
  int head [3];
  int tail [3];

  initial begin
    for (int l = 0; l < 3; l++) begin
      vin[l] = 1'b0; din[l] = 8'h00; rdy[l] = 1'b0;
      sent[l] = 0; got[l] = 0; cnt[l] = 0; head[l] = 0; tail[l] = 0;
    end
    rstn = 1'b0;

    // Reset held with random inputs
    for (int c = 0; c < 4; c++) begin
      drive(1'($urandom), 8'($urandom), 1'($urandom));
      check("rst_vld", 32'(ovld[0]), 0);
      check("rst_dout", 32'(dout[0]), 0);
      check("rst_occ", occ_of(0), 0);
      check("rst_rdy", 32'(irdy[0]), 1);
      tick();
    end
    drive(0, 8'h00, 0);
    rstn = 1'b1;
    tick();

    // Load one word, then assert reset asynchronously mid-cycle
    drive(1, 8'h5A, 0);
    tick();
    drive(0, 8'h00, 0);
    tick(); tick(); tick();
    check("pre_rst_vld", 32'(ovld[0]), 1);
    check("pre_rst_dout", 32'(dout[0]), 32'h5A);
    check("pre_rst_occ", occ_of(0), 1);
    rstn = 1'b0;
    #1;
    check("async_vld", 32'(ovld[0]), 0);
    check("async_dout", 32'(dout[0]), 0);
    check("async_occ", occ_of(0), 0);
    check("async_rdy", 32'(irdy[0]), 1);
    tick();
    rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drive(0, 8'h00, 1);
      check("post_rst_vld", 32'(ovld[0]), 0);
      tick();
    end

    // Streaming 0x01..0x10 with the consumer always ready
    for (int k = 0; k < 22; k++) begin
      int acc_n, dlv_n;
      drive(k < 16, 8'(k + 1), 1);
      acc_n = (k < 16) ? k : 16;
      dlv_n = (k < 4) ? 0 : ((k - 4 > 16) ? 16 : k - 4);
      check("strm_rdy", 32'(irdy[0]), 1);
      check("strm_vld", 32'(ovld[0]), 32'(k >= 4 && k < 20));
      if (k >= 4 && k < 20) check("strm_dout", 32'(dout[0]), 32'(k - 3));
      check("strm_occ", occ_of(0), 32'(acc_n - dlv_n));
      tick();
    end

    // Fill and stall
    for (int c = 0; c < 4; c++) begin
      drive(1, 8'(8'hA0 + c), 0);
      check("fill_rdy", 32'(irdy[0]), 1);
      check("fill_occ", occ_of(0), 32'(c));
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      drive(1, 8'hA4, 0);
      check("stall_rdy", 32'(irdy[0]), 0);
      check("stall_occ", occ_of(0), 4);
      check("stall_vld", 32'(ovld[0]), 1);
      check("stall_dout", 32'(dout[0]), 32'hA0);
      tick();
    end
    for (int c = 0; c < 6; c++) begin
      drive(c < 2, 8'(8'hA4 + c), 1);
      check("rel_rdy", 32'(irdy[0]), 1);
      check("rel_vld", 32'(ovld[0]), 1);
      check("rel_dout", 32'(dout[0]), 32'(8'hA0 + c));
      check("rel_occ", occ_of(0), (c <= 2) ? 32'd4 : 32'(6 - c));
      tick();
    end
    drive(0, 8'h00, 1);
    check("rel_empty_vld", 32'(ovld[0]), 0);
    check("rel_empty_occ", occ_of(0), 0);

    // Bubble collapse against a stalled output
    drive(1, 8'h11, 0); tick();
    drive(0, 8'h00, 0); tick(); tick();
    drive(1, 8'h22, 0); tick();
    for (int c = 0; c < 6; c++) begin
      drive(0, 8'h00, 0);
      tick();
    end
    drive(0, 8'h00, 0);
    check("bub_occ", occ_of(0), 2);
    check("bub_rdy", 32'(irdy[0]), 1);
    check("bub_vld", 32'(ovld[0]), 1);
    check("bub_dout", 32'(dout[0]), 32'h11);
    drive(0, 8'h00, 1);
    tick();
    drive(0, 8'h00, 1);
    check("bub_vld2", 32'(ovld[0]), 1);
    check("bub_dout2", 32'(dout[0]), 32'h22);
    tick();
    drive(0, 8'h00, 1);
    check("bub_empty_vld", 32'(ovld[0]), 0);
    check("bub_empty_occ", occ_of(0), 0);

    // Full-pipe pass-through
    for (int c = 0; c < 4; c++) begin
      drive(1, 8'(8'hB0 + c), 0);
      check("pt_fill_rdy", 32'(irdy[0]), 1);
      tick();
    end
    for (int c = 0; c < 8; c++) begin
      drive(1, 8'(8'hB4 + c), 1);
      check("pt_rdy", 32'(irdy[0]), 1);
      check("pt_occ", occ_of(0), 4);
      check("pt_vld", 32'(ovld[0]), 1);
      check("pt_dout", 32'(dout[0]), 32'(8'hB0 + c));
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      drive(0, 8'h00, 1);
      check("pt_drain_vld", 32'(ovld[0]), 1);
      check("pt_drain_dout", 32'(dout[0]), 32'(8'hB8 + c));
      tick();
    end
    drive(0, 8'h00, 1);
    check("pt_empty_vld", 32'(ovld[0]), 0);
    check("pt_empty_occ", occ_of(0), 0);
    tick();

    // Random traffic on depths 4, 1 and 7 against a FIFO model
    begin
      int cyc;
      bit done;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 60000) begin
        for (int l = 0; l < 3; l++) begin
          vin[l] = (sent[l] < 10000) && ($urandom_range(0, 1) == 1);
          din[l] = 8'($urandom);
          rdy[l] = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        for (int l = 0; l < 3; l++) begin
          check(occ_tag[l], occ_of(l), 32'(cnt[l]));
          if (ovld[l] && rdy[l]) begin
            if (cnt[l] == 0) begin
              check("underflow", 32'(ovld[l]), 0);
            end else begin
              check(data_tag[l], 32'(dout[l]), 32'(mem[l][head[l]]));
              head[l] = (head[l] + 1) % 16;
              cnt[l]--;
              got[l]++;
            end
          end
          if (vin[l] && irdy[l]) begin
            mem[l][tail[l]] = din[l];
            tail[l] = (tail[l] + 1) % 16;
            cnt[l]++;
            sent[l]++;
          end
        end
        tick();
        cyc++;
        done = (got[0] >= 10000) && (got[1] >= 10000) && (got[2] >= 10000);
      end
      check("rand_timeout", 32'(done), 1);
      for (int l = 0; l < 3; l++) begin
        check("rand_count", 32'(got[l]), 32'(sent[l]));
        check("rand_final_occ", occ_of(l), 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
